// File: rtl/memory_stage_pkg.sv
// Shared pipeline types for the memory stage: control word, access size and
// data-memory FSM state encodings.
package rvga_types;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } rvga_mem_size;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_REQ,
    DMEM_WAIT,
    DMEM_DONE
  } rvga_dmem_state;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        rd_w_v;
    logic        ld_v;
    logic        st_v;
    logic [1:0]  mem_size;
    logic        mem_uns;
  } rvga_cword;

  function automatic logic is_mem_op(input rvga_cword c);
    return c.ld_v | c.st_v;
  endfunction

endpackage

// File: rtl/dff.sv
// Generic enabled register with asynchronous active-low reset to zero.
module dff #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [width_p-1:0] d_i,
  output logic [width_p-1:0] q_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/memory_stage_align.sv
// Byte-lane steering for data-memory accesses: store mask/data replication,
// load extraction with sign/zero extension, and misalignment detection.
module mem_align
  import rvga_types::*;
(
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] st_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted      = rdata_i >> {lane_i, 3'b000};
    wmask_o      = 4'hF;
    wdata_o      = st_data_i;
    ld_data_o    = shifted;
    misaligned_o = 1'b0;
    case (size_i)
      MEM_B: begin
        wmask_o   = 4'b0001 << lane_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
      end
      MEM_H: begin
        wmask_o      = 4'b0011 << lane_i;
        wdata_o      = {2{st_data_i[15:0]}};
        ld_data_o    = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
        misaligned_o = lane_i[0];
      end
      default: begin
        misaligned_o = |lane_i;
      end
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues data-memory loads/stores over a valid/ready
// request and response-valid interface, stalling the pipe while outstanding.
module memory_stage
  import rvga_types::*;
#(
  parameter int unsigned addr_width_p = 32,
  parameter int unsigned max_wait_p   = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    stall_v_i,
  input  rvga_cword               cword_i,
  input  logic [31:0]             alu_result_i,
  input  logic [31:0]             st_data_i,
  output logic                    dmem_req_v_o,
  input  logic                    dmem_ready_i,
  output logic                    dmem_we_o,
  output logic [addr_width_p-1:0] dmem_addr_o,
  output logic [31:0]             dmem_wdata_o,
  output logic [3:0]              dmem_wmask_o,
  input  logic                    dmem_rdata_v_i,
  input  logic [31:0]             dmem_rdata_i,
  output logic [31:0]             alu_or_ld_result_o,
  output logic                    stall_v_o,
  output logic                    mem_err_o
);

  rvga_dmem_state state_q, state_d;
  logic           err_q, err_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d, wait_cnt_inc;
  logic [31:0]    rdata_buf_q, rdata_buf_d;
  logic           mem_op;
  logic           misaligned;
  logic [3:0]     wmask;
  logic [31:0]    wdata;
  logic [31:0]    ld_data;
  logic           unused_cword;

  assign mem_op       = is_mem_op(cword_i);
  assign unused_cword = ^{cword_i.pc, cword_i.rd, cword_i.rd_w_v};

  mem_align u_align (
    .size_i       (cword_i.mem_size),
    .uns_i        (cword_i.mem_uns),
    .lane_i       (alu_result_i[1:0]),
    .st_data_i    (st_data_i),
    .rdata_i      (rdata_buf_q),
    .wmask_o      (wmask),
    .wdata_o      (wdata),
    .ld_data_o    (ld_data),
    .misaligned_o (misaligned)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= DMEM_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  dff #(.width_p(8)) u_wait_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .d_i   (wait_cnt_d),
    .q_o   (wait_cnt_q)
  );

  dff #(.width_p(32)) u_rdata_buf (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .d_i   (rdata_buf_d),
    .q_o   (rdata_buf_q)
  );

  always_comb begin
    state_d            = state_q;
    err_d              = err_q;
    wait_cnt_d         = '0;
    wait_cnt_inc       = wait_cnt_q + 8'd1;
    rdata_buf_d        = rdata_buf_q;
    dmem_req_v_o       = 1'b0;
    stall_v_o          = 1'b0;
    alu_or_ld_result_o = alu_result_i;
    case (state_q)
      DMEM_IDLE: begin
        if (mem_op) begin
          if (misaligned) begin
            err_d              = 1'b1;
            alu_or_ld_result_o = '0;
          end else begin
            state_d   = DMEM_REQ;
            stall_v_o = 1'b1;
          end
        end
      end
      DMEM_REQ: begin
        dmem_req_v_o = 1'b1;
        stall_v_o    = 1'b1;
        if (dmem_ready_i) begin
          state_d = cword_i.st_v ? DMEM_DONE : DMEM_WAIT;
        end
      end
      DMEM_WAIT: begin
        stall_v_o = 1'b1;
        // A response in the final allowed cycle still wins over the timeout.
        if (dmem_rdata_v_i) begin
          rdata_buf_d = dmem_rdata_i;
          state_d     = DMEM_DONE;
        end else if (wait_cnt_inc == 8'(max_wait_p)) begin
          err_d       = 1'b1;
          rdata_buf_d = '0;
          state_d     = DMEM_DONE;
        end else begin
          wait_cnt_d = wait_cnt_inc;
        end
      end
      DMEM_DONE: begin
        if (cword_i.ld_v && !cword_i.st_v) begin
          alu_or_ld_result_o = ld_data;
        end
        if (!stall_v_i) begin
          state_d = DMEM_IDLE;
        end
      end
      default: begin
        state_d = DMEM_IDLE;
      end
    endcase
  end

  assign mem_err_o    = err_q;
  assign dmem_we_o    = dmem_req_v_o & cword_i.st_v;
  assign dmem_addr_o  = dmem_req_v_o ? {alu_result_i[addr_width_p-1:2], 2'b00} : '0;
  assign dmem_wdata_o = dmem_req_v_o ? wdata : '0;
  assign dmem_wmask_o = dmem_req_v_o ? wmask : '0;

endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a byte-level
// reference model of loads, stores and the access timing.
module tb_memory_stage;
  import rvga_types::*;

  localparam int unsigned MAXW = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_v_i;
  rvga_cword   cw;
  logic [31:0] alu_result_i, st_data_i;
  logic        dmem_req_v_o, dmem_ready_i, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_wmask_o;
  logic        dmem_rdata_v_i;
  logic [31:0] dmem_rdata_i, alu_or_ld_result_o;
  logic        stall_v_o, mem_err_o;

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  memory_stage #(.addr_width_p(32), .max_wait_p(MAXW)) dut (
    .clk_i              (clk),
    .rst_i              (rst_n),
    .stall_v_i          (stall_v_i),
    .cword_i            (cw),
    .alu_result_i       (alu_result_i),
    .st_data_i          (st_data_i),
    .dmem_req_v_o       (dmem_req_v_o),
    .dmem_ready_i       (dmem_ready_i),
    .dmem_we_o          (dmem_we_o),
    .dmem_addr_o        (dmem_addr_o),
    .dmem_wdata_o       (dmem_wdata_o),
    .dmem_wmask_o       (dmem_wmask_o),
    .dmem_rdata_v_i     (dmem_rdata_v_i),
    .dmem_rdata_i       (dmem_rdata_i),
    .alu_or_ld_result_o (alu_or_ld_result_o),
    .stall_v_o          (stall_v_o),
    .mem_err_o          (mem_err_o)
  );

  // Reference model: value a load returns from a memory word.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int unsigned lane,
                                           input int unsigned nb, input bit uns);
    logic [63:0] v;
    logic [63:0] m;
    m = (64'd1 << (8 * nb)) - 64'd1;
    v = ({32'd0, w} >> (8 * lane)) & m;
    if (!uns && ((v >> (8 * nb - 1)) & 64'd1) == 64'd1) v = v | ~m;
    return v[31:0];
  endfunction

  // Reference model: mask/data must write exactly the nb low store bytes at lane.
  function automatic bit ref_store_ok(input logic [3:0] mask, input logic [31:0] wd,
                                      input logic [31:0] sd, input int unsigned lane,
                                      input int unsigned nb);
    bit ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit en = (k >= int'(lane)) && (k < int'(lane + nb));
      if (mask[k] !== en) ok = 1'b0;
      if (en && (wd[8*k +: 8] !== sd[8*(k-int'(lane)) +: 8])) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int unsigned exp_stall(input bit ld, input int unsigned rdy,
                                            input int unsigned resp, input bit no_resp);
    if (!ld) return 2 + rdy;
    return 2 + rdy + (no_resp ? MAXW : resp + 1);
  endfunction

  task automatic set_nop();
    cw = '0;
    st_data_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    stall_v_i = 1'b0;
    dmem_ready_i = 1'b0;
    dmem_rdata_v_i = 1'b0;
    dmem_rdata_i = '0;
    alu_result_i = '0;
    set_nop();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Drives one operation and plays the memory side; returns observations only.
  task automatic do_access(
    input  bit ld, input bit st, input logic [1:0] sz, input bit uns,
    input  logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rword,
    input  int unsigned rdy_dly, input int unsigned resp_dly, input bit no_resp,
    input  int unsigned hold,
    output int unsigned stall_n, output int unsigned acc_n,
    output logic [31:0] o_addr, output logic [3:0] o_mask, output logic [31:0] o_wdata,
    output logic o_we, output logic [31:0] o_res, output bit stable, output bit hung);
    int unsigned req_seen = 0;
    int unsigned wcyc = 0;
    bit accepted = 1'b0;
    bit first_req = 1'b1;
    cw = '0;
    cw.pc = $urandom;
    cw.rd = 5'($urandom);
    cw.rd_w_v = ld;
    cw.ld_v = ld;
    cw.st_v = st;
    cw.mem_size = sz;
    cw.mem_uns = uns;
    alu_result_i = addr;
    st_data_i = sdata;
    stall_v_i = 1'b0;
    stall_n = 0; acc_n = 0; stable = 1'b1; hung = 1'b1;
    o_addr = '0; o_mask = '0; o_wdata = '0; o_we = 1'b0; o_res = '0;
    for (int c = 0; c < 64; c++) begin
      #1;
      dmem_ready_i = 1'b0;
      dmem_rdata_v_i = 1'b0;
      dmem_rdata_i = $urandom;
      if (stall_v_o) begin
        stall_n++;
        if (dmem_req_v_o) begin
          if (first_req) begin
            o_addr = dmem_addr_o; o_mask = dmem_wmask_o; o_wdata = dmem_wdata_o; o_we = dmem_we_o;
          end else if (o_addr !== dmem_addr_o || o_mask !== dmem_wmask_o ||
                       o_wdata !== dmem_wdata_o || o_we !== dmem_we_o) begin
            stable = 1'b0;
          end
          first_req = 1'b0;
          if (req_seen == rdy_dly) begin
            dmem_ready_i = 1'b1;
            acc_n++;
            accepted = 1'b1;
          end
          req_seen++;
        end else if (accepted && ld) begin
          if (!no_resp && wcyc == resp_dly) begin
            dmem_rdata_v_i = 1'b1;
            dmem_rdata_i = rword;
          end
          wcyc++;
        end
      end else begin
        if (dmem_req_v_o) acc_n += 100;
        o_res = alu_or_ld_result_o;
        stall_v_i = (hold != 0);
        for (int h = 0; h < int'(hold); h++) begin
          @(negedge clk);
          #1;
          if (alu_or_ld_result_o !== o_res || stall_v_o || dmem_req_v_o) stable = 1'b0;
          if (h == int'(hold) - 1) stall_v_i = 1'b0;
        end
        hung = 1'b0;
        @(negedge clk);
        dmem_rdata_v_i = 1'b0;
        set_nop();
        break;
      end
      @(negedge clk);
    end
    if (hung) begin
      dmem_ready_i = 1'b0;
      dmem_rdata_v_i = 1'b0;
      set_nop();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    stall_v_i = 1'b0;
    dmem_ready_i = 1'b0;
    dmem_rdata_v_i = 1'b0;
    dmem_rdata_i = '0;
    alu_result_i = '0;
    set_nop();
    #3;
    tests++;
    if ({dmem_req_v_o, dmem_we_o, stall_v_o, mem_err_o} !== 4'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got req/we/stall/err=%b want 0000",
               {dmem_req_v_o, dmem_we_o, stall_v_o, mem_err_o});
    end
    tests++;
    if (dmem_addr_o !== '0 || dmem_wdata_o !== '0 || dmem_wmask_o !== '0 || alu_or_ld_result_o !== '0) begin
      fails++;
      $display("FAIL reset_data: got addr=%h wdata=%h mask=%h res=%h want all 0",
               dmem_addr_o, dmem_wdata_o, dmem_wmask_o, alu_or_ld_result_o);
    end
    do_reset();
  endtask

  task automatic test_alu_passthrough();
    int unsigned sn, an; logic [31:0] a, wd, r, v; logic [3:0] m; logic we; bit stb, hg;
    for (int i = 0; i < 6; i++) begin
      v = (i == 0) ? 32'h0000_1234 : $urandom;
      do_access(0, 0, 2'($urandom_range(0, 2)), 1'($urandom), v, $urandom, 0, 0, 0, 0, 0,
                sn, an, a, m, wd, we, r, stb, hg);
      tests++;
      if (hg || r !== v || sn != 0 || an != 0) begin
        fails++;
        $display("FAIL alu_pass[%0d]: got res=%h stall=%0d req=%0d hung=%0b want res=%h stall=0 req=0",
                 i, r, sn, an, hg, v);
      end
    end
  endtask

  task automatic test_store();
    int unsigned sn, an, rdy, lane, nb; logic [31:0] a, wd, r, ad, sd; logic [3:0] m; logic we;
    bit stb, hg; logic [1:0] sz;
    do_access(0, 1, MEM_W, 0, 32'h100, 32'hDEAD_BEEF, 0, 1, 0, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
    tests++;
    if (hg || a !== 32'h100 || m !== 4'hF || wd !== 32'hDEAD_BEEF || we !== 1'b1) begin
      fails++;
      $display("FAIL sw_fields: got addr=%h mask=%h wdata=%h we=%b want 00000100 f deadbeef 1", a, m, wd, we);
    end
    tests++;
    if (sn != 3 || an != 1 || !stb) begin
      fails++;
      $display("FAIL sw_timing: got stall=%0d acc=%0d stable=%0b want 3 1 1", sn, an, stb);
    end
    for (int i = 0; i < 10; i++) begin
      sz = 2'($urandom_range(0, 2));
      nb = 1 << sz;
      lane = $urandom_range(0, 3) & ~(nb - 1);
      ad = ($urandom & ~32'h3) | lane;
      sd = $urandom;
      rdy = $urandom_range(0, 3);
      do_access(0, 1, sz, 1'($urandom), ad, sd, 0, rdy, 0, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
      tests++;
      if (hg || !ref_store_ok(m, wd, sd, lane, nb) || a !== (ad & ~32'h3) || we !== 1'b1 ||
          r !== ad || sn != exp_stall(0, rdy, 0, 0) || an != 1 || !stb) begin
        fails++;
        $display("FAIL st_rand[%0d]: got addr=%h mask=%h wdata=%h res=%h stall=%0d acc=%0d want addr=%h sd=%h lane=%0d nb=%0d stall=%0d",
                 i, a, m, wd, r, sn, an, ad & ~32'h3, sd, lane, nb, exp_stall(0, rdy, 0, 0));
      end
    end
  endtask

  task automatic test_load();
    int unsigned sn, an, rdy, rsp, lane, nb; logic [31:0] a, wd, r, ad, rw; logic [3:0] m; logic we;
    bit stb, hg, u; logic [1:0] sz;
    rw = {8'h80, 24'($urandom)};
    do_access(1, 0, MEM_B, 0, 32'h203, 0, rw, 0, 0, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
    tests++;
    if (hg || r !== 32'hFFFF_FF80 || a !== 32'h200 || we !== 1'b0) begin
      fails++;
      $display("FAIL lb: got res=%h addr=%h we=%b want ffffff80 00000200 0", r, a, we);
    end
    do_access(1, 0, MEM_B, 1, 32'h203, 0, rw, 0, 0, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
    tests++;
    if (hg || r !== 32'h0000_0080 || sn != 3) begin
      fails++;
      $display("FAIL lbu: got res=%h stall=%0d want 00000080 3", r, sn);
    end
    for (int i = 0; i < 12; i++) begin
      sz = 2'($urandom_range(0, 2));
      nb = 1 << sz;
      lane = $urandom_range(0, 3) & ~(nb - 1);
      ad = ($urandom & ~32'h3) | lane;
      rw = $urandom;
      u = 1'($urandom);
      rdy = $urandom_range(0, 2);
      rsp = $urandom_range(0, MAXW - 1);
      do_access(1, 0, sz, u, ad, $urandom, rw, rdy, rsp, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
      tests++;
      if (hg || r !== ref_load(rw, lane, nb, u) || a !== (ad & ~32'h3) || we !== 1'b0 ||
          sn != exp_stall(1, rdy, rsp, 0) || an != 1 || !stb) begin
        fails++;
        $display("FAIL ld_rand[%0d]: got res=%h addr=%h stall=%0d acc=%0d want res=%h addr=%h stall=%0d",
                 i, r, a, sn, an, ref_load(rw, lane, nb, u), ad & ~32'h3, exp_stall(1, rdy, rsp, 0));
      end
    end
    tests++;
    if (mem_err_o !== 1'b0) begin
      fails++;
      $display("FAIL no_err_aligned: got err=%b want 0", mem_err_o);
    end
  endtask

  task automatic test_half_and_misaligned();
    int unsigned sn, an, nb; logic [31:0] a, wd, r, ad; logic [3:0] m; logic we; bit stb, hg, isld;
    logic [1:0] sz;
    do_reset();
    do_access(0, 1, MEM_H, 0, 32'h302, 32'h0000_ABCD, 0, 0, 0, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
    tests++;
    if (hg || m !== 4'hC || wd !== 32'hABCD_ABCD || a !== 32'h300 || mem_err_o !== 1'b0) begin
      fails++;
      $display("FAIL sh: got mask=%h wdata=%h addr=%h err=%b want c abcdabcd 00000300 0", m, wd, a, mem_err_o);
    end
    do_access(1, 0, MEM_H, 0, 32'h301, 0, $urandom, 0, 0, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
    tests++;
    if (hg || an != 0 || sn != 0 || r !== 32'h0 || mem_err_o !== 1'b1) begin
      fails++;
      $display("FAIL lh_misaligned: got req=%0d stall=%0d res=%h err=%b want 0 0 0 1", an, sn, r, mem_err_o);
    end
    for (int i = 0; i < 6; i++) begin
      do_reset();
      sz = 2'($urandom_range(1, 2));
      nb = 1 << sz;
      ad = ($urandom & ~32'h3) | ((nb == 2) ? ((2 * $urandom_range(0, 1)) + 1) : $urandom_range(1, 3));
      isld = 1'($urandom);
      do_access(isld, !isld, sz, 1'($urandom), ad, $urandom, $urandom, 0, 0, 0, 0,
                sn, an, a, m, wd, we, r, stb, hg);
      tests++;
      if (hg || an != 0 || sn != 0 || r !== 32'h0 || mem_err_o !== 1'b1) begin
        fails++;
        $display("FAIL misal_rand[%0d]: got req=%0d stall=%0d res=%h err=%b addr=%h nb=%0d want 0 0 0 1",
                 i, an, sn, r, mem_err_o, ad, nb);
      end
    end
  endtask

  task automatic test_done_hold();
    int unsigned sn, an; logic [31:0] a, wd, r, rw; logic [3:0] m; logic we; bit stb, hg;
    do_reset();
    rw = $urandom;
    do_access(1, 0, MEM_W, 0, 32'h440, 0, rw, 1, 1, 0, 4, sn, an, a, m, wd, we, r, stb, hg);
    tests++;
    if (hg || r !== rw || !stb || an != 1 || sn != exp_stall(1, 1, 1, 0)) begin
      fails++;
      $display("FAIL lw_hold: got res=%h stable=%0b acc=%0d stall=%0d want res=%h stable=1 acc=1 stall=%0d",
               r, stb, an, sn, rw, exp_stall(1, 1, 1, 0));
    end
  endtask

  task automatic test_back_to_back();
    int unsigned sn, an, rdy, rsp, lane, nb; logic [31:0] a, wd, r, ad, rw, sd, want;
    logic [3:0] m; logic we; bit stb, hg, isld, u; logic [1:0] sz;
    for (int i = 0; i < 10; i++) begin
      sz = 2'($urandom_range(0, 2));
      nb = 1 << sz;
      lane = $urandom_range(0, 3) & ~(nb - 1);
      ad = ($urandom & ~32'h3) | lane;
      isld = 1'($urandom);
      u = 1'($urandom);
      rw = $urandom;
      sd = $urandom;
      rdy = $urandom_range(0, 2);
      rsp = $urandom_range(0, MAXW - 1);
      do_access(isld, !isld, sz, u, ad, sd, rw, rdy, rsp, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
      want = isld ? ref_load(rw, lane, nb, u) : ad;
      tests++;
      if (hg || r !== want || an != 1 || sn != exp_stall(isld, rdy, rsp, 0)) begin
        fails++;
        $display("FAIL b2b[%0d]: got res=%h acc=%0d stall=%0d want res=%h acc=1 stall=%0d",
                 i, r, an, sn, want, exp_stall(isld, rdy, rsp, 0));
      end
    end
  endtask

  task automatic test_timeout_and_reset();
    int unsigned sn, an; logic [31:0] a, wd, r, rw; logic [3:0] m; logic we; bit stb, hg;
    do_reset();
    do_access(1, 0, MEM_W, 0, 32'h500, 0, $urandom, 0, 0, 1, 0, sn, an, a, m, wd, we, r, stb, hg);
    tests++;
    if (hg || r !== 32'h0 || mem_err_o !== 1'b1 || sn != exp_stall(1, 0, 0, 1)) begin
      fails++;
      $display("FAIL timeout: got res=%h err=%b stall=%0d hung=%0b want 0 1 %0d 0",
               r, mem_err_o, sn, hg, exp_stall(1, 0, 0, 1));
    end
    cw = '0;
    cw.ld_v = 1'b1;
    cw.mem_size = MEM_W;
    alu_result_i = 32'h600;
    @(negedge clk);
    #1;
    tests++;
    if (dmem_req_v_o !== 1'b1 || mem_err_o !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got req=%b err=%b want 1 1", dmem_req_v_o, mem_err_o);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (dmem_req_v_o !== 1'b0 || mem_err_o !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got req=%b err=%b want 0 0", dmem_req_v_o, mem_err_o);
    end
    set_nop();
    alu_result_i = 32'h0000_7777;
    @(negedge clk);
    rst_n = 1'b1;
    dmem_rdata_v_i = 1'b1;
    dmem_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    #1;
    tests++;
    if (stall_v_o !== 1'b0 || dmem_req_v_o !== 1'b0 || alu_or_ld_result_o !== 32'h0000_7777) begin
      fails++;
      $display("FAIL late_resp: got stall=%b req=%b res=%h want 0 0 00007777",
               stall_v_o, dmem_req_v_o, alu_or_ld_result_o);
    end
    dmem_rdata_v_i = 1'b0;
    @(negedge clk);
    rw = $urandom;
    do_access(1, 0, MEM_W, 0, 32'h604, 0, rw, 0, 2, 0, 0, sn, an, a, m, wd, we, r, stb, hg);
    tests++;
    if (hg || r !== rw || an != 1 || mem_err_o !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_lw: got res=%h acc=%0d err=%b want %h 1 0", r, an, mem_err_o, rw);
    end
  endtask

  initial begin
    test_reset();
    test_alu_passthrough();
    test_store();
    test_load();
    test_half_and_misaligned();
    test_done_hold();
    test_back_to_back();
    test_timeout_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly upstream of writeback.
- Takes the execute-stage control word, ALU result and store data, and performs data-memory loads/stores over a valid/ready request + response-valid interface.
- Produces `alu_or_ld_result_o`, which writeback registers.
- Asserts `stall_v_o` to freeze the pipeline while a memory access is outstanding.

Parameters:
- addr_width_p, 32, byte-address width driven on `dmem_addr_o`.
- max_wait_p, 255, response-wait cycles before `mem_err_o` fires; 8-bit counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-low reset.
- stall_v_i  in  1  downstream/global stall; stage holds its state.
- cword_i  in  $bits(rvga_cword)  control word: pc, rd, rd_w_v, ld_v, st_v, mem_size, mem_uns.
- alu_result_i  in  32  ALU result, also the effective address.
- st_data_i  in  32  rs2 store data.
- dmem_req_v_o  out  1  request valid.
- dmem_ready_i  in  1  memory accepts the request this cycle.
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  addr_width_p  word-aligned address (bits 1:0 = 0).
- dmem_wdata_o  out  32  lane-shifted store data.
- dmem_wmask_o  out  4  byte-enable mask.
- dmem_rdata_v_i  in  1  load response valid.
- dmem_rdata_i  in  32  load response word.
- alu_or_ld_result_o  out  32  result for writeback.
- stall_v_o  out  1  access outstanding.
- mem_err_o  out  1  sticky: misaligned access or timeout.

Behaviour:
- States: IDLE, REQ, WAIT, DONE.
- Reset values: state IDLE; all outputs 0; `rdata_buf` 0; wait counter 0; `mem_err_o` 0.
- Non-memory op (`ld_v` = `st_v` = 0):
  - `alu_or_ld_result_o` = `alu_result_i`, combinationally.
  - `stall_v_o` = 0 and no request is issued.
- IDLE, memory op, aligned:
  - Go to REQ; `stall_v_o` = 1 combinationally in the same cycle.
  - Request fields are driven combinationally from `cword_i`/`alu_result_i`, which are frozen upstream by the stall.
- REQ:
  - `dmem_req_v_o` = 1.
  - On `dmem_ready_i`: a store goes to DONE; a load goes to WAIT.
  - Request fields hold constant until `dmem_ready_i`.
- WAIT:
  - On `dmem_rdata_v_i`: capture `dmem_rdata_i` into `rdata_buf` and go to DONE.
  - Otherwise increment the wait counter.
  - When the counter reaches max_wait_p: set `mem_err_o` and go to DONE with `rdata_buf` = 0.
- DONE:
  - `stall_v_o` = 0; `alu_or_ld_result_o` = extracted load value (stores: `alu_result_i`).
  - If `stall_v_i` = 0, return to IDLE next cycle; otherwise hold DONE (buffer held).
  - No second request is issued for the same op.
- Responses arriving one cycle after ready are legal.
- A response in the same cycle as ready is illegal; the bench must not drive it.
- Size encoding (`mem_size`): 0 = byte, 1 = half, 2 = word.
  - Lane = `alu_result_i[1:0]`.
  - Byte: mask `4'b0001 << lane`; wdata = `{4{st[7:0]}}`.
  - Half: mask `4'b0011 << lane`; wdata = `{2{st[15:0]}}`.
  - Word: mask `4'hF`.
- Load extraction: shift `rdata_buf` right by 8·lane, then sign-extend, or zero-extend when `mem_uns` = 1.
- Misaligned access (half with `addr[0]` set; word with `addr[1:0]` ≠ 0):
  - No request issued; sets `mem_err_o`; result = 0; `stall_v_o` = 0.
- `stall_v_i` in REQ/WAIT: the memory handshake continues (the external memory is not stalled); only the DONE→IDLE exit waits.
- `mem_err_o` clears only on reset.
- Reset mid-access: immediate return to IDLE; `dmem_req_v_o` drops asynchronously; late responses arriving in IDLE are ignored.
- Back-to-back memory ops: after DONE→IDLE, the next op's request is issued one cycle later at the earliest.

Decomposition:
- `rvga_types` gains `ld_v`, `st_v`, `mem_size` (2b) and `mem_uns` in `rvga_cword`, plus a `rvga_mem_size` enum (MEM_B, MEM_H, MEM_W) and a `rvga_dmem_state` enum.
- One sub-module: `mem_align`, purely combinational. It generates the store mask and lane-shifted data, performs load extraction/extension, and detects misalignment.
- The wait counter and `rdata_buf` use the existing `dff` cell.

Test Plan:
- `addi`-style op, `alu_result_i` = 0x0000_1234 → result 0x0000_1234 in the same cycle, `stall_v_o` = 0, `dmem_req_v_o` never asserted.
- `sw` 0xDEAD_BEEF @ 0x100, ready after 2 cycles → addr 0x100, mask 0xF, wdata 0xDEAD_BEEF; `stall_v_o` high 3 cycles; exactly one accepted request.
- `lb` @ 0x203, rdata 0x80xx_xxxx, response 1 cycle after ready → result 0xFFFF_FF80; `lbu` same → 0x0000_0080.
- `sh` 0x0000_ABCD @ 0x302 → mask 0xC, wdata 0xABCD_ABCD; `lh` @ 0x301 → no request, `mem_err_o` = 1, result 0.
- `lw` with `stall_v_i` held high 4 cycles after the response → DONE held, result stable at the loaded value, no re-request.
- `lw` with no response, max_wait_p = 4 → `mem_err_o` after 4 WAIT cycles; then reset asserted mid-REQ of the next load → `dmem_req_v_o` = 0 and `mem_err_o` = 0 immediately.
